sdram_arbit: RTL and testbench

// - Command arbiter that sits directly after sdram_init and sdram_ar. It also

---
 rtl/sdram_arbit_if.sv | 68 ++++++
 rtl/sdram_arbit.sv | 192 +++++++++++++++++++
 tb/tb_sdram_arbit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbit_if.sv
// ---------------------------------------------------------------------------
// sdram_arbit_if
// Bundles the command/handshake signals that pass between the SDRAM
// sub-engines (init, auto-refresh, write, read) and the command arbiter,
// plus the muxed SDRAM command pins.
//   slave  : the arbiter side (takes requests and commands, drives grants and pins)
//   master : the engine/controller side (drives requests and commands, sees grants)
// The bidirectional DQ bus stays a plain module port on the arbiter so that
// tri-state resolution happens on an ordinary net.
// ---------------------------------------------------------------------------
interface sdram_arbit_if #(
    parameter int ADDR_W = 13,
    parameter int BANK_W = 2,
    parameter int DATA_W = 16
);
    // init engine
    logic [3:0]        init_cmd;
    logic [BANK_W-1:0] init_bank;
    logic [ADDR_W-1:0] init_addr;
    logic              init_end;
    // auto-refresh engine
    logic              ar_req;
    logic              ar_end;
    logic [3:0]        ar_cmd;
    logic [BANK_W-1:0] ar_bank;
    logic [ADDR_W-1:0] ar_addr;
    logic              ar_en;
    // write engine
    logic              wr_req;
    logic              wr_end;
    logic [3:0]        wr_cmd;
    logic [BANK_W-1:0] wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_sdram_en;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    // read engine
    logic              rd_req;
    logic              rd_end;
    logic [3:0]        rd_cmd;
    logic [BANK_W-1:0] rd_bank;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    // SDRAM command pins
    logic              sdram_cke;
    logic [3:0]        sdram_cmd;
    logic [BANK_W-1:0] sdram_bank;
    logic [ADDR_W-1:0] sdram_addr;

    modport slave (
        input  init_cmd, init_bank, init_addr, init_end,
        input  ar_req, ar_end, ar_cmd, ar_bank, ar_addr,
        input  wr_req, wr_end, wr_cmd, wr_bank, wr_addr, wr_sdram_en, wr_data,
        input  rd_req, rd_end, rd_cmd, rd_bank, rd_addr,
        output ar_en, wr_en, rd_en, rd_data,
        output sdram_cke, sdram_cmd, sdram_bank, sdram_addr
    );

    modport master (
        output init_cmd, init_bank, init_addr, init_end,
        output ar_req, ar_end, ar_cmd, ar_bank, ar_addr,
        output wr_req, wr_end, wr_cmd, wr_bank, wr_addr, wr_sdram_en, wr_data,
        output rd_req, rd_end, rd_cmd, rd_bank, rd_addr,
        input  ar_en, wr_en, rd_en, rd_data,
        input  sdram_cke, sdram_cmd, sdram_bank, sdram_addr
    );
endinterface

// File: rtl/sdram_arbit.sv
// ---------------------------------------------------------------------------
// sdram_arbit
// SDRAM command arbiter. After initialisation completes it grants one of the
// auto-refresh, write or read engines at a time (refresh > write > read),
// drives that engine's registered enable, muxes its cmd/bank/addr onto the
// SDRAM pins and owns the tri-state DQ bus. A grant is held until the
// engine's *_end pulse; at least one ARBIT (NOP) cycle separates grants.
//
// Ports
//   arb_clk    in     system clock, rising edge
//   arb_rst_n  in     asynchronous active-low reset
//   bus        slave  sdram_arbit_if: engine requests/commands, grants
//                     (ar_en/wr_en/rd_en), rd_data, SDRAM cmd/bank/addr/cke
//   sdram_dq   inout  SDRAM data bus, driven with wr_data only while the write
//                     engine holds the grant and asserts wr_sdram_en
//
// Configuration
//   ARB_RR_EN  when defined, write and read alternate while both are pending
//              (refresh keeps top priority); when undefined, write strictly
//              beats read.
// ---------------------------------------------------------------------------
module sdram_arbit #(
    parameter int ADDR_W = 13,
    parameter int BANK_W = 2,
    parameter int DATA_W = 16
) (
    input  logic              arb_clk,
    input  logic              arb_rst_n,
    sdram_arbit_if.slave      bus,
    inout  wire  [DATA_W-1:0] sdram_dq
);

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        ARBIT = 3'b001,
        AREF  = 3'b011,
        WRITE = 3'b010,
        READ  = 3'b110
    } state_t;

    localparam logic [3:0] CMD_NOP = 4'b0111;

    state_t state_q, state_d;
    logic   ar_en_q, ar_en_d;
    logic   wr_en_q, wr_en_d;
    logic   rd_en_q, rd_en_d;
    logic   grant_wr;

`ifdef ARB_RR_EN
    // 1 = the most recent write/read grant went to the write engine
    logic   last_grant_q, last_grant_d;

    // When both are waiting, the engine that was not served last goes first.
    assign grant_wr = bus.wr_req && !(bus.rd_req && last_grant_q);
`else
    assign grant_wr = bus.wr_req;
`endif

    always_comb begin
        state_d = state_q;
        ar_en_d = ar_en_q;
        wr_en_d = wr_en_q;
        rd_en_d = rd_en_q;
`ifdef ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            // init_end is only looked at here; once arbitration starts it is ignored.
            IDLE: begin
                if (bus.init_end) state_d = ARBIT;
            end
            ARBIT: begin
                if (bus.ar_req) begin
                    state_d = AREF;
                    ar_en_d = 1'b1;
                end else if (grant_wr) begin
                    state_d = WRITE;
                    wr_en_d = 1'b1;
`ifdef ARB_RR_EN
                    last_grant_d = 1'b1;
`endif
                end else if (bus.rd_req) begin
                    state_d = READ;
                    rd_en_d = 1'b1;
`ifdef ARB_RR_EN
                    last_grant_d = 1'b0;
`endif
                end
            end
            // Each grant ends only on its own engine's end pulse.
            AREF: begin
                if (bus.ar_end) begin
                    state_d = ARBIT;
                    ar_en_d = 1'b0;
                end
            end
            WRITE: begin
                if (bus.wr_end) begin
                    state_d = ARBIT;
                    wr_en_d = 1'b0;
                end
            end
            READ: begin
                if (bus.rd_end) begin
                    state_d = ARBIT;
                    rd_en_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                ar_en_d = 1'b0;
                wr_en_d = 1'b0;
                rd_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge arb_clk or negedge arb_rst_n) begin
        if (!arb_rst_n) begin
            state_q      <= IDLE;
            ar_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
`ifdef ARB_RR_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ar_en_q      <= ar_en_d;
            wr_en_q      <= wr_en_d;
            rd_en_q      <= rd_en_d;
`ifdef ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Pin mux decodes the current state directly so that an asynchronous
    // reset hands the pins back to the init engine without waiting for a clock.
    logic [3:0]        cmd_mux;
    logic [BANK_W-1:0] bank_mux;
    logic [ADDR_W-1:0] addr_mux;

    always_comb begin
        cmd_mux  = CMD_NOP;
        bank_mux = '1;
        addr_mux = '1;
        case (state_q)
            IDLE: begin
                cmd_mux  = bus.init_cmd;
                bank_mux = bus.init_bank;
                addr_mux = bus.init_addr;
            end
            AREF: begin
                cmd_mux  = bus.ar_cmd;
                bank_mux = bus.ar_bank;
                addr_mux = bus.ar_addr;
            end
            WRITE: begin
                cmd_mux  = bus.wr_cmd;
                bank_mux = bus.wr_bank;
                addr_mux = bus.wr_addr;
            end
            READ: begin
                cmd_mux  = bus.rd_cmd;
                bank_mux = bus.rd_bank;
                addr_mux = bus.rd_addr;
            end
            default: begin
                cmd_mux  = CMD_NOP;
                bank_mux = '1;
                addr_mux = '1;
            end
        endcase
    end

    assign bus.sdram_cke  = 1'b1;
    assign bus.sdram_cmd  = cmd_mux;
    assign bus.sdram_bank = bank_mux;
    assign bus.sdram_addr = addr_mux;

    assign bus.ar_en = ar_en_q;
    assign bus.wr_en = wr_en_q;
    assign bus.rd_en = rd_en_q;

    // DQ is only driven while the write engine owns the bus and asks for it.
    logic dq_oe;
    assign dq_oe       = (state_q == WRITE) && bus.wr_sdram_en;
    assign sdram_dq    = dq_oe ? bus.wr_data : {DATA_W{1'bz}};
    assign bus.rd_data = sdram_dq;

endmodule

// File: tb/tb_sdram_arbit.sv
module tb_sdram_arbit;

    localparam int ADDR_W = 13;
    localparam int BANK_W = 2;
    localparam int DATA_W = 16;

    // Pin sources, identified by their distinctive cmd/bank/addr values
    localparam int SRC_I = 0;  // init
    localparam int SRC_N = 1;  // NOP (ARBIT)
    localparam int SRC_A = 2;  // auto-refresh
    localparam int SRC_W = 3;  // write
    localparam int SRC_R = 4;  // read

    logic arb_clk   = 1'b0;
    logic arb_rst_n = 1'b0;
    always #5 arb_clk = ~arb_clk;

    sdram_arbit_if #(.ADDR_W(ADDR_W), .BANK_W(BANK_W), .DATA_W(DATA_W)) bus ();

    wire  [DATA_W-1:0] sdram_dq;
    logic              tb_oe = 1'b0;
    logic [DATA_W-1:0] tb_dq = '0;
    assign sdram_dq = tb_oe ? tb_dq : {DATA_W{1'bz}};

    sdram_arbit #(.ADDR_W(ADDR_W), .BANK_W(BANK_W), .DATA_W(DATA_W)) dut (
        .arb_clk   (arb_clk),
        .arb_rst_n (arb_rst_n),
        .bus       (bus.slave),
        .sdram_dq  (sdram_dq)
    );

    // Vector inputs packed as {init_end, ar_req, ar_end, wr_req, wr_end, rd_req, rd_end}
    typedef struct {
        bit [6:0] in;
        bit [2:0] en;   // expected {ar_en, wr_en, rd_en} after the next edge
        int       src;  // expected pin source after the next edge
    } vec_t;

    typedef struct {
        bit [2:0] en;
        int       src;
        int       idx;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [18:0] pins(int src);
        case (src)
            SRC_I:   return {4'b0010, 2'b01, 13'h0400};
            SRC_A:   return {4'b0001, 2'b10, 13'h0A0A};
            SRC_W:   return {4'b0100, 2'b00, 13'h0123};
            SRC_R:   return {4'b0101, 2'b01, 13'h0456};
            default: return {4'b0111, 2'b11, 13'h1FFF};
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_state(string name, bit [2:0] en, int src);
        chk({name, "_en"}, {29'd0, bus.ar_en, bus.wr_en, bus.rd_en}, {29'd0, en});
        chk({name, "_pins"}, {13'd0, bus.sdram_cmd, bus.sdram_bank, bus.sdram_addr},
            {13'd0, pins(src)});
    endtask

    task automatic add(bit [6:0] in, bit [2:0] en, int src, int n);
        for (int k = 0; k < n; k++) tbl.push_back('{in, en, src});
    endtask

    task automatic apply(bit [6:0] in);
        {bus.init_end, bus.ar_req, bus.ar_end, bus.wr_req, bus.wr_end,
         bus.rd_req, bus.rd_end} = in;
    endtask

    // Scoreboard monitor: compares the DUT just after each rising edge
    // against the expectation queued when that cycle's stimulus was driven.
    exp_t e;
    always @(posedge arb_clk) begin
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_state($sformatf("vec%0d", e.idx), e.en, e.src);
        end
    end

    initial begin
        {bus.init_cmd, bus.init_bank, bus.init_addr} = pins(SRC_I);
        {bus.ar_cmd,   bus.ar_bank,   bus.ar_addr}   = pins(SRC_A);
        {bus.wr_cmd,   bus.wr_bank,   bus.wr_addr}   = pins(SRC_W);
        {bus.rd_cmd,   bus.rd_bank,   bus.rd_addr}   = pins(SRC_R);
        bus.wr_sdram_en = 1'b0;
        bus.wr_data     = '0;
        apply(7'b0000000);

        //   in (ie ar ae wr we rd re)  en    src
        add(7'b0000000, 3'b000, SRC_I, 1);  // init not done: IDLE
        add(7'b1000000, 3'b000, SRC_N, 1);  // init_end -> ARBIT
        add(7'b0000000, 3'b000, SRC_N, 1);  // init_end dropping is ignored
        add(7'b0100000, 3'b100, SRC_A, 1);  // refresh grant
        add(7'b0000000, 3'b100, SRC_A, 1);
        add(7'b0000100, 3'b100, SRC_A, 1);  // foreign wr_end ignored
        add(7'b0010000, 3'b000, SRC_N, 1);  // ar_end -> ARBIT
        add(7'b0000000, 3'b000, SRC_N, 1);
        add(7'b0101010, 3'b100, SRC_A, 1);  // all three: refresh wins
        add(7'b0001010, 3'b100, SRC_A, 4);
        add(7'b0011010, 3'b000, SRC_N, 1);  // ar_end 5 clks after grant
        add(7'b0001010, 3'b010, SRC_W, 5);  // write next
        add(7'b0000110, 3'b000, SRC_N, 1);  // wr_end
        add(7'b0000010, 3'b001, SRC_R, 5);  // read last
        add(7'b0000001, 3'b000, SRC_N, 1);  // rd_end
        add(7'b0001010, 3'b010, SRC_W, 1);  // both pending, write first
        add(7'b0001011, 3'b010, SRC_W, 1);  // foreign rd_end ignored
        add(7'b0001110, 3'b000, SRC_N, 1);  // wr_end, both still requesting
`ifdef ARB_RR_EN
        add(7'b0001010, 3'b001, SRC_R, 1);  // alternation: read's turn
`else
        add(7'b0001010, 3'b010, SRC_W, 1);  // strict priority: write again
`endif
        add(7'b0000101, 3'b000, SRC_N, 1);  // whichever was granted ends
        add(7'b0000000, 3'b000, SRC_N, 1);

        #1;
        check_state("reset", 3'b000, SRC_I);
        chk("cke", {31'd0, bus.sdram_cke}, 32'd1);
        repeat (10) @(negedge arb_clk);
        arb_rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge arb_clk);
            apply(tbl[i].in);
            sb.push_back('{tbl[i].en, tbl[i].src, i});
        end
        @(negedge arb_clk);
        apply(7'b0000000);
        for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge arb_clk);
        chk("scoreboard_drained", sb.size(), 0);

        // Write with DQ drive, refresh request arriving mid-write
        bus.wr_req = 1'b1;
        @(posedge arb_clk); #1;
        check_state("wr_grant", 3'b010, SRC_W);
        @(negedge arb_clk);
        bus.wr_req = 1'b0;
        bus.wr_sdram_en = 1'b1;
        bus.wr_data = 16'hA5A5;
        bus.ar_req = 1'b1;
        #1;
        chk("dq_drive", {16'd0, sdram_dq}, 32'h0000A5A5);
        @(posedge arb_clk); #1;
        check_state("ar_no_preempt", 3'b010, SRC_W);
        @(negedge arb_clk);
        bus.wr_sdram_en = 1'b0;
        tb_oe = 1'b1;
        tb_dq = 16'h5A5A;
        #1;
        chk("dq_release", {16'd0, bus.rd_data}, 32'h00005A5A);
        @(negedge arb_clk);
        tb_oe = 1'b0;
        bus.wr_end = 1'b1;
        @(posedge arb_clk); #1;
        check_state("wr_done", 3'b000, SRC_N);
        @(negedge arb_clk);
        bus.wr_end = 1'b0;
        @(posedge arb_clk); #1;
        check_state("ar_after_wr", 3'b100, SRC_A);
        @(negedge arb_clk);
        bus.ar_req = 1'b0;
        bus.ar_end = 1'b1;
        @(posedge arb_clk); #1;
        check_state("ar_done", 3'b000, SRC_N);
        @(negedge arb_clk);
        bus.ar_end = 1'b0;

        // Read with bench-driven DQ
        bus.rd_req = 1'b1;
        @(posedge arb_clk); #1;
        check_state("rd_grant", 3'b001, SRC_R);
        @(negedge arb_clk);
        bus.rd_req = 1'b0;
        tb_oe = 1'b1;
        tb_dq = 16'h1234;
        #1;
        chk("rd_data", {16'd0, bus.rd_data}, 32'h00001234);
        @(negedge arb_clk);
        tb_oe = 1'b0;
        bus.rd_end = 1'b1;
        @(posedge arb_clk); #1;
        check_state("rd_done", 3'b000, SRC_N);
        @(negedge arb_clk);
        bus.rd_end = 1'b0;

        // Asynchronous reset in the middle of a write
        bus.wr_req = 1'b1;
        @(posedge arb_clk); #1;
        check_state("wr_grant2", 3'b010, SRC_W);
        @(negedge arb_clk);
        bus.wr_req = 1'b0;
        #2;
        arb_rst_n = 1'b0;
        #1;
        check_state("rst_mid_wr", 3'b000, SRC_I);
        @(posedge arb_clk); #1;
        check_state("rst_hold", 3'b000, SRC_I);
        @(negedge arb_clk);
        arb_rst_n = 1'b1;
        @(posedge arb_clk); #1;
        check_state("idle_wait", 3'b000, SRC_I);
        @(negedge arb_clk);
        bus.init_end = 1'b1;
        @(posedge arb_clk); #1;
        check_state("rearm", 3'b000, SRC_N);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
